// File: rtl/pixel_compositor_pkg.sv
// rtl/pixel_compositor_pkg.sv - shared constants and helpers for the pixel compositor
//
// Purpose: pixel width, coordinate width, colour constants, hit counter width
//          and the reduction-tree sizing helper used by pixel_compositor.
// Ports:   none (package).
package pixel_compositor_pkg;

   localparam int PIX_W    = 12;   // RGB 4:4:4
   localparam int COORD_W  = 10;
   localparam int HITCNT_W = 19;

   localparam logic [PIX_W-1:0]    COLOR_BLACK = 12'h000;
   localparam logic [PIX_W-1:0]    COLOR_WHITE = 12'hFFF;
   localparam logic [HITCNT_W-1:0] HITCNT_MAX  = 19'h7FFFF;

   // Number of live entries at reduction level l of an n-input pairwise tree.
   function automatic int lvl_count(input int n, input int l);
      return (n + (1 << l) - 1) >> l;
   endfunction

endpackage

// File: rtl/pixel_compositor_pick2.sv
// rtl/pixel_compositor_pick2.sv - combinational pairwise depth pick
//
// Purpose: picks the winner of two (hit, level, pixel) entries; a is the lower
//          shader index. A lone hit wins; with two hits the larger level wins
//          and a wins a tie; with no hits the result is a no-hit.
// Ports:   a_hit/a_level/a_pixel, b_hit/b_level/b_pixel  - candidates
//          w_hit/w_level/w_pixel                         - winner
module pixel_compositor_pick2
   import pixel_compositor_pkg::*;
#(
   parameter int LEVEL_W = 8
) (
   input  logic               a_hit,
   input  logic [LEVEL_W-1:0] a_level,
   input  logic [PIX_W-1:0]   a_pixel,
   input  logic               b_hit,
   input  logic [LEVEL_W-1:0] b_level,
   input  logic [PIX_W-1:0]   b_pixel,
   output logic               w_hit,
   output logic [LEVEL_W-1:0] w_level,
   output logic [PIX_W-1:0]   w_pixel
);

   logic b_wins;

   always_comb begin
      // Strict compare keeps the lower index on equal levels.
      b_wins  = b_hit && (!a_hit || (b_level > a_level));
      w_hit   = a_hit | b_hit;
      w_level = b_wins ? b_level : a_level;
      w_pixel = b_wins ? b_pixel : a_pixel;
   end

endmodule

// File: rtl/pixel_compositor.sv
// rtl/pixel_compositor.sv - pipelined depth-ordered compositor of shader outputs
//
// Purpose: stage 0 registers all shader triples, then each stage registers one
//          level of a pairwise pick tree; x/y/video_on travel alongside so they
//          stay aligned with out_pixel. Latency is 1 + $clog2(NUM_SHADERS).
// Optional: define PIXEL_COMPOSITOR_HITCNT_EN to add the per-frame hit counter
//          (hit_count output, frame_start delay line and accumulator).
// Ports:   clk, reset (sync, active high), pause (1 = hold every register)
//          x, y, video_on, frame_start          - pixel entering the pipe
//          pixels, levels, hits                 - packed per-shader triples
//          out_pixel, out_x, out_y, out_video_on, out_hit - aligned results
//          hit_count                            - hits of the last frame (optional)
module pixel_compositor
   import pixel_compositor_pkg::*;
#(
   parameter int               NUM_SHADERS = 4,
   parameter int               LEVEL_W     = 8,
   parameter logic [PIX_W-1:0] BG_COLOR    = COLOR_BLACK
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           pause,
   input  logic [COORD_W-1:0]             x,
   input  logic [COORD_W-1:0]             y,
   input  logic                           video_on,
   input  logic                           frame_start,
   input  logic [NUM_SHADERS*PIX_W-1:0]   pixels,
   input  logic [NUM_SHADERS*LEVEL_W-1:0] levels,
   input  logic [NUM_SHADERS-1:0]         hits,
   output logic [PIX_W-1:0]               out_pixel,
   output logic [COORD_W-1:0]             out_x,
   output logic [COORD_W-1:0]             out_y,
   output logic                           out_video_on,
   output logic                           out_hit
`ifdef PIXEL_COMPOSITOR_HITCNT_EN
   ,
   output logic [HITCNT_W-1:0]            hit_count
`endif
);

   localparam int LVLS = $clog2(NUM_SHADERS);
   localparam int LAT  = LVLS + 1;

   // Level 0 is the input register; level l holds the l-th reduction result.
   logic               st_hit [0:LVLS][NUM_SHADERS];
   logic [LEVEL_W-1:0] st_lvl [0:LVLS][NUM_SHADERS];
   logic [PIX_W-1:0]   st_pix [0:LVLS][NUM_SHADERS];
   logic               nx_hit [0:LVLS][NUM_SHADERS];
   logic [LEVEL_W-1:0] nx_lvl [0:LVLS][NUM_SHADERS];
   logic [PIX_W-1:0]   nx_pix [0:LVLS][NUM_SHADERS];

   logic [COORD_W-1:0] x_d  [LAT];
   logic [COORD_W-1:0] y_d  [LAT];
   logic               vo_d [LAT];

   genvar gl, gj;
   generate
      for (gj = 0; gj < NUM_SHADERS; gj++) begin : g_in
         assign nx_hit[0][gj] = hits[gj];
         assign nx_lvl[0][gj] = levels[LEVEL_W*gj +: LEVEL_W];
         assign nx_pix[0][gj] = pixels[PIX_W*gj +: PIX_W];
      end
      for (gl = 1; gl <= LVLS; gl++) begin : g_lvl
         for (gj = 0; gj < NUM_SHADERS; gj++) begin : g_ent
            if (gj < lvl_count(NUM_SHADERS, gl)) begin : g_live
               if (2*gj + 1 < lvl_count(NUM_SHADERS, gl - 1)) begin : g_pair
                  pixel_compositor_pick2 #(.LEVEL_W(LEVEL_W)) u_pick (
                     .a_hit   (st_hit[gl-1][2*gj]),
                     .a_level (st_lvl[gl-1][2*gj]),
                     .a_pixel (st_pix[gl-1][2*gj]),
                     .b_hit   (st_hit[gl-1][2*gj+1]),
                     .b_level (st_lvl[gl-1][2*gj+1]),
                     .b_pixel (st_pix[gl-1][2*gj+1]),
                     .w_hit   (nx_hit[gl][gj]),
                     .w_level (nx_lvl[gl][gj]),
                     .w_pixel (nx_pix[gl][gj])
                  );
               end else begin : g_odd
                  // Odd entry rides through this level unchanged.
                  assign nx_hit[gl][gj] = st_hit[gl-1][2*gj];
                  assign nx_lvl[gl][gj] = st_lvl[gl-1][2*gj];
                  assign nx_pix[gl][gj] = st_pix[gl-1][2*gj];
               end
            end else begin : g_dead
               assign nx_hit[gl][gj] = 1'b0;
               assign nx_lvl[gl][gj] = '0;
               assign nx_pix[gl][gj] = '0;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int l = 0; l <= LVLS; l++) begin
            for (int j = 0; j < NUM_SHADERS; j++) begin
               st_hit[l][j] <= 1'b0;
               st_lvl[l][j] <= '0;
               st_pix[l][j] <= '0;
            end
         end
         for (int i = 0; i < LAT; i++) begin
            x_d[i]  <= '0;
            y_d[i]  <= '0;
            vo_d[i] <= 1'b0;
         end
      end else if (!pause) begin
         for (int l = 0; l <= LVLS; l++) begin
            for (int j = 0; j < NUM_SHADERS; j++) begin
               st_hit[l][j] <= nx_hit[l][j];
               st_lvl[l][j] <= nx_lvl[l][j];
               st_pix[l][j] <= nx_pix[l][j];
            end
         end
         x_d[0]  <= x;
         y_d[0]  <= y;
         vo_d[0] <= video_on;
         for (int i = 1; i < LAT; i++) begin
            x_d[i]  <= x_d[i-1];
            y_d[i]  <= y_d[i-1];
            vo_d[i] <= vo_d[i-1];
         end
      end
   end

   assign out_x        = x_d[LAT-1];
   assign out_y        = y_d[LAT-1];
   assign out_video_on = vo_d[LAT-1];
   assign out_hit      = st_hit[LVLS][0];
   assign out_pixel    = !out_video_on ? COLOR_BLACK :
                         !out_hit      ? BG_COLOR    : st_pix[LVLS][0];

`ifdef PIXEL_COMPOSITOR_HITCNT_EN
   logic                fs_d [LAT];
   logic [HITCNT_W-1:0] acc;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LAT; i++) fs_d[i] <= 1'b0;
         acc       <= '0;
         hit_count <= '0;
      end else if (!pause) begin
         fs_d[0] <= frame_start;
         for (int i = 1; i < LAT; i++) fs_d[i] <= fs_d[i-1];
         if (fs_d[LAT-1]) begin
            // The frame-start pixel itself opens the new frame's tally.
            hit_count <= acc;
            acc       <= {{(HITCNT_W-1){1'b0}}, out_video_on && out_hit};
         end else if (out_video_on && out_hit && (acc != HITCNT_MAX)) begin
            acc <= acc + 1'b1;
         end
      end
   end
`else
   logic unused_frame_start;
   assign unused_frame_start = frame_start;
`endif

endmodule
